// File: rtl/int_add_acc_drain_if.sv
// Bundle of the sample input stream, result handshake and drop status for
// int_add_acc_drain. The master drives samples and out_ready; the slave is the accumulator.
interface int_add_acc_drain_if #(
    parameter int DATA_PATH_BITWIDTH = 32,
    parameter int ACC_LEN_LOG2       = 4,
    parameter int DROP_CNT_BITWIDTH  = 16
);
    logic                                       in_valid;
    logic [DATA_PATH_BITWIDTH-1:0]              in_data;
    logic                                       in_apx;
    logic                                       in_ready;
    logic                                       out_valid;
    logic                                       out_ready;
    logic [DATA_PATH_BITWIDTH+ACC_LEN_LOG2-1:0] out_sum;
    logic [DATA_PATH_BITWIDTH-1:0]              out_mean;
    logic [ACC_LEN_LOG2:0]                      out_apx_cnt;
    logic [DROP_CNT_BITWIDTH-1:0]               drop_cnt;
    logic                                       drop_flag;

    modport master (
        output in_valid, in_data, in_apx, out_ready,
        input  in_ready, out_valid, out_sum, out_mean, out_apx_cnt, drop_cnt, drop_flag
    );

    modport slave (
        input  in_valid, in_data, in_apx, out_ready,
        output in_ready, out_valid, out_sum, out_mean, out_apx_cnt, drop_cnt, drop_flag
    );
endinterface

// File: rtl/int_add_acc_drain.sv
// Accumulates blocks of 2^ACC_LEN_LOG2 adder results and presents sum, mean and
// approximate-sample count over a valid/ready handshake, counting samples dropped under back-pressure.
module int_add_acc_drain #(
    parameter int DATA_PATH_BITWIDTH = 32,
    parameter int ACC_LEN_LOG2       = 4,
    parameter int DROP_CNT_BITWIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    int_add_acc_drain_if.slave   bus
);
    localparam int SUM_W = DATA_PATH_BITWIDTH + ACC_LEN_LOG2;
    localparam int CNT_W = ACC_LEN_LOG2 + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'((1 << ACC_LEN_LOG2) - 1);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t                       state_reg, state_next;
    logic [SUM_W-1:0]             acc_reg, acc_next;
    logic [CNT_W-1:0]             cnt_reg, cnt_next;
    logic [CNT_W-1:0]             apx_acc_reg, apx_acc_next;
    logic [SUM_W-1:0]             sum_out_reg, sum_out_next;
    logic [CNT_W-1:0]             apx_out_reg, apx_out_next;
    logic [DROP_CNT_BITWIDTH-1:0] drop_cnt_reg, drop_cnt_next;
    logic                         drop_flag_reg, drop_flag_next;

    logic             in_ready;
    logic             accept;
    logic             drop;
    logic [SUM_W-1:0] data_ext;
    logic [CNT_W-1:0] apx_ext;

    // While a result is held, a new sample is only taken when the result leaves on the same edge.
    assign in_ready = (state_reg == ACCUM) || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;
    assign drop     = bus.in_valid && !in_ready;
    assign data_ext = SUM_W'(bus.in_data);
    assign apx_ext  = CNT_W'(bus.in_apx);

    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        cnt_next       = cnt_reg;
        apx_acc_next   = apx_acc_reg;
        sum_out_next   = sum_out_reg;
        apx_out_next   = apx_out_reg;
        drop_cnt_next  = drop_cnt_reg;
        drop_flag_next = drop_flag_reg;

        case (state_reg)
            ACCUM: begin
                if (accept) begin
                    if (cnt_reg == LAST_IDX) begin
                        sum_out_next = acc_reg + data_ext;
                        apx_out_next = apx_acc_reg + apx_ext;
                        acc_next     = '0;
                        cnt_next     = '0;
                        apx_acc_next = '0;
                        state_next   = HOLD;
                    end else begin
                        acc_next     = acc_reg + data_ext;
                        cnt_next     = cnt_reg + CNT_W'(1);
                        apx_acc_next = apx_acc_reg + apx_ext;
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_next = ACCUM;
                    // A block is at least two samples, so the sample taken here never completes one.
                    if (accept) begin
                        acc_next     = data_ext;
                        cnt_next     = CNT_W'(1);
                        apx_acc_next = apx_ext;
                    end else begin
                        acc_next     = '0;
                        cnt_next     = '0;
                        apx_acc_next = '0;
                    end
                end
            end
            default: state_next = ACCUM;
        endcase

        if (drop) begin
            drop_flag_next = 1'b1;
            if (drop_cnt_reg != {DROP_CNT_BITWIDTH{1'b1}})
                drop_cnt_next = drop_cnt_reg + DROP_CNT_BITWIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ACCUM;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            apx_acc_reg   <= '0;
            sum_out_reg   <= '0;
            apx_out_reg   <= '0;
            drop_cnt_reg  <= '0;
            drop_flag_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            cnt_reg       <= cnt_next;
            apx_acc_reg   <= apx_acc_next;
            sum_out_reg   <= sum_out_next;
            apx_out_reg   <= apx_out_next;
            drop_cnt_reg  <= drop_cnt_next;
            drop_flag_reg <= drop_flag_next;
        end
    end

    // Mean is the held sum with the block-length bits shifted out.
    generate
        for (genvar gi = 0; gi < DATA_PATH_BITWIDTH; gi++) begin : g_mean
            assign bus.out_mean[gi] = sum_out_reg[gi+ACC_LEN_LOG2];
        end
    endgenerate

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = (state_reg == HOLD);
    assign bus.out_sum     = sum_out_reg;
    assign bus.out_apx_cnt = apx_out_reg;
    assign bus.drop_cnt    = drop_cnt_reg;
    assign bus.drop_flag   = drop_flag_reg;
endmodule
